// File: rtl/aggr_seq_if.sv
// Signal bundle between the per-event aggregation sequencer (master) and its
// neighbour FIFO, MAC unit, max-aggregator and downstream layer (slave).
interface aggr_seq_if #(
  parameter int MAX_NBR = 16,
  parameter int NBR_W   = 16
);
  localparam int CNT_W = $clog2(MAX_NBR + 1);

  logic             evt_valid;
  logic             evt_ready;
  logic             nbr_empty;
  logic             nbr_done;
  logic             nbr_rd_en;
  logic [NBR_W-1:0] nbr_rdata;
  logic             mac_valid;
  logic             mac_ready;
  logic [NBR_W-1:0] mac_nbr;
  logic             mac_done;
  logic             is_neighbor;
  logic             no_neighbor;
  logic             clean;
  logic             aggr_valid;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] nbr_count;
  logic             nbr_trunc;
  logic             busy;

  modport master (
    input  evt_valid, nbr_empty, nbr_done, nbr_rdata, mac_ready, mac_done,
           aggr_valid, out_ready,
    output evt_ready, nbr_rd_en, mac_valid, mac_nbr, is_neighbor, no_neighbor,
           clean, out_valid, nbr_count, nbr_trunc, busy
  );

  modport slave (
    output evt_valid, nbr_empty, nbr_done, nbr_rdata, mac_ready, mac_done,
           aggr_valid, out_ready,
    input  evt_ready, nbr_rd_en, mac_valid, mac_nbr, is_neighbor, no_neighbor,
           clean, out_valid, nbr_count, nbr_trunc, busy
  );
endinterface

// File: rtl/aggr_seq.sv
// Per-event sequencer for one graph-conv layer: pops neighbours, issues one MAC
// job each, steers the max-aggregator and hands the result downstream.
module aggr_seq #(
  parameter int MAX_NBR = 16,
  parameter int NBR_W   = 16
) (
  input logic        clk,
  input logic        rstn,
  aggr_seq_if.master bus
);
  localparam int               CNT_W   = $clog2(MAX_NBR + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NBR);

  typedef enum logic [3:0] {
    IDLE, FETCH, POP, ISSUE, COMPUTE, WAIT_AGGR, OUTPUT, CLEAN, DRAIN
  } state_t;

  state_t           state;
  logic [NBR_W-1:0] mac_nbr_q;
  logic [CNT_W-1:0] count_q;
  logic             trunc_q;
  logic             mac_valid_q;
  logic             is_nbr_q;
  logic             no_nbr_q;
  logic             clean_q;
  logic             out_valid_q;
  logic             clean_2nd_q;
  logic             at_max;
  logic             fetch_pop;
  logic             drain_pop;

  assign at_max = (count_q == CNT_MAX);

  // The FIFO pop is decoded from state (not registered) so that read data
  // arrives exactly in the POP cycle, and DRAIN can pop every cycle.
  assign fetch_pop = (state == FETCH) && !at_max && !bus.nbr_empty;
  assign drain_pop = (state == DRAIN) && !bus.nbr_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      mac_nbr_q   <= '0;
      count_q     <= '0;
      trunc_q     <= 1'b0;
      mac_valid_q <= 1'b0;
      is_nbr_q    <= 1'b0;
      no_nbr_q    <= 1'b0;
      clean_q     <= 1'b0;
      out_valid_q <= 1'b0;
      clean_2nd_q <= 1'b0;
    end else begin
      no_nbr_q <= 1'b0;
      clean_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.evt_valid) begin
            count_q <= '0;
            trunc_q <= 1'b0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (at_max) begin
            if (!bus.nbr_empty) trunc_q <= 1'b1;
            no_nbr_q <= 1'b1;
            state    <= WAIT_AGGR;
          end else if (!bus.nbr_empty) begin
            state <= POP;
          end else if (bus.nbr_done) begin
            no_nbr_q <= 1'b1;
            state    <= WAIT_AGGR;
          end
        end
        POP: begin
          mac_nbr_q   <= bus.nbr_rdata;
          mac_valid_q <= 1'b1;
          is_nbr_q    <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (bus.mac_ready) begin
            mac_valid_q <= 1'b0;
            is_nbr_q    <= 1'b0;
            state       <= COMPUTE;
          end
        end
        // Waiting for mac_done keeps no_neighbor behind the last accumulate.
        COMPUTE: begin
          if (bus.mac_done) begin
            if (!at_max) count_q <= count_q + CNT_W'(1);
            state <= FETCH;
          end
        end
        WAIT_AGGR: begin
          if (bus.aggr_valid) begin
            out_valid_q <= 1'b1;
            state       <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            clean_q     <= 1'b1;
            clean_2nd_q <= 1'b0;
            state       <= CLEAN;
          end
        end
        CLEAN: begin
          clean_2nd_q <= 1'b1;
          if (clean_2nd_q) state <= trunc_q ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (bus.nbr_empty && bus.nbr_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.evt_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.nbr_rd_en   = fetch_pop || drain_pop;
  assign bus.mac_valid   = mac_valid_q;
  assign bus.mac_nbr     = mac_nbr_q;
  assign bus.is_neighbor = is_nbr_q;
  assign bus.no_neighbor = no_nbr_q;
  assign bus.clean       = clean_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.nbr_count   = count_q;
  assign bus.nbr_trunc   = trunc_q;
endmodule

// File: doc/aggr_seq.md
Name: aggr_seq

Overview:
- Per-event sequencer for one graph-conv layer.
- Accepts an event and pops its neighbour indices from the neighbour FIFO.
- Issues one linear-transform (MAC) job per neighbour and drives the max-aggregator controls is_neighbor, no_neighbor and clean.
- Presents the aggregated feature to the downstream layer through a valid/ready handshake, then cleans the aggregator for the next event.

Parameters:
- MAX_NBR, 16: maximum neighbours processed per event; further entries are drained and discarded.
- NBR_W, 16: width of a neighbour index.
- CNT_W, $clog2(MAX_NBR+1): neighbour counter width (derived; do not override).

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- evt_valid  in  1  new event available
- evt_ready  out  1  sequencer idle; event accepted when evt_valid && evt_ready
- nbr_empty  in  1  neighbour FIFO empty
- nbr_done  in  1  neighbour search finished; no further FIFO pushes for this event (level, held until the next event)
- nbr_rd_en  out  1  FIFO pop; data valid on nbr_rdata one cycle later
- nbr_rdata  in  NBR_W  FIFO read data
- mac_valid  out  1  MAC job request
- mac_ready  in  1  MAC accepts job
- mac_nbr  out  NBR_W  neighbour index of the job
- mac_done  in  1  job result valid; coincides with accum_out_valid at the aggregator
- is_neighbor  out  1  to aggregator
- no_neighbor  out  1  to aggregator
- clean  out  1  to aggregator
- aggr_valid  in  1  from aggregator
- out_valid  out  1  aggregated feature valid downstream
- out_ready  in  1  downstream accepts
- nbr_count  out  CNT_W  neighbours processed for the current/last event
- nbr_trunc  out  1  current/last event exceeded MAX_NBR
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, FETCH, POP, ISSUE, COMPUTE, WAIT_AGGR, OUTPUT, CLEAN, DRAIN.
- Reset: state=IDLE; nbr_count=0; nbr_trunc=0; mac_nbr=0. All pulse and valid outputs are 0. evt_ready=1 after reset.
- Reset mid-operation: immediate return to IDLE. An in-flight MAC result is ignored. The aggregator shares rstn and needs no clean.
- IDLE:
  - evt_ready=1.
  - On handshake: clear nbr_count and nbr_trunc, then go to FETCH.
- FETCH (priority order):
  - nbr_count==MAX_NBR: if !nbr_empty, set nbr_trunc. Pulse no_neighbor for 1 cycle and go to WAIT_AGGR.
  - !nbr_empty: pulse nbr_rd_en and go to POP.
  - nbr_empty && nbr_done: pulse no_neighbor and go to WAIT_AGGR.
  - Otherwise stay in FETCH.
- POP:
  - Latch nbr_rdata into mac_nbr and go to ISSUE.
- ISSUE:
  - mac_valid=1 and is_neighbor=1, both held until mac_ready.
  - On mac_ready go to COMPUTE.
- COMPUTE:
  - Wait for mac_done, then nbr_count++ and go to FETCH.
  - mac_done outside COMPUTE is ignored.
  - Because the sequencer waits for mac_done, no_neighbor is always at least 1 cycle after the last accum_out_valid. The aggregator therefore never misses a result.
- Zero neighbours: no_neighbor without any prior is_neighbor. The aggregator enters pass-through and outputs 0.
- WAIT_AGGR:
  - Wait for aggr_valid (expected 1 cycle after no_neighbor), then go to OUTPUT.
- OUTPUT:
  - out_valid=1, held until out_ready; data is stable on the aggregator bus.
  - On handshake: pulse clean for 1 cycle, then go to CLEAN.
  - If out_ready is already high on entry, the handshake occurs in the first OUTPUT cycle.
- CLEAN:
  - 2 cycles (aggregator CLEAN plus return to IDLE).
  - Then go to DRAIN if nbr_trunc, else IDLE.
- DRAIN:
  - nbr_rd_en=1 every cycle while !nbr_empty; data is discarded.
  - Exit to IDLE when nbr_empty && nbr_done.
- Outputs that are not pulses hold their values between events. nbr_count saturates at MAX_NBR.
- evt_valid while busy: not accepted; evt_ready=0.
- Minimum latency per neighbour: FETCH→POP→ISSUE→COMPUTE is 4 cycles when mac_ready and mac_done arrive immediately.

Test Plan:
- Event with 3 neighbours pre-loaded, nbr_done=1, mac_ready=1, mac_done 2 cycles after accept -> mac_nbr sequence matches FIFO order. is_neighbor pulses 3 times. no_neighbor pulses once after the 3rd mac_done. out_valid asserted; nbr_count=3; nbr_trunc=0.
- Event with empty FIFO and nbr_done=1 -> no mac_valid. no_neighbor 1 cycle after FETCH entry. out_valid with aggregator output 0. clean pulses on handshake; back in IDLE 3 cycles later.
- FIFO empty, nbr_done=0 for 10 cycles, then 1 entry pushed and nbr_done=1 -> sequencer waits in FETCH with no pulses, then processes 1 neighbour; nbr_count=1.
- 20 entries with MAX_NBR=16 -> exactly 16 MAC jobs. nbr_trunc=1; nbr_count=16. After clean, the remaining 4 entries are popped in DRAIN, then IDLE with nbr_empty=1.
- out_ready held low for 5 cycles, mac_ready delayed 3 cycles -> out_valid and mac_valid/mac_nbr stay stable throughout. clean pulses only on the cycle of the out_valid && out_ready handshake.
- rstn low for 1 cycle while in COMPUTE -> next cycle IDLE, all outputs at reset values, evt_ready=1. A late mac_done is ignored and nbr_count stays 0.
